// File: rtl/apb_dram_pkg.sv
// apb_dram_pkg: shared constants and command payload for the APB-to-DRAM command bridge.
//   - Register word offsets decoded from paddr.
//   - STATUS register bit positions.
//   - cmd_t: one DRAM controller request {write, addr, wdata}.
package apb_dram_pkg;

  localparam int unsigned CMD_ADDR_W = 16;
  localparam int unsigned CMD_DATA_W = 16;

  // Register word offsets
  localparam int unsigned REG_ADDR   = 0;
  localparam int unsigned REG_WDATA  = 1;
  localparam int unsigned REG_CMD    = 2;
  localparam int unsigned REG_STATUS = 3;
  localparam int unsigned REG_RDATA  = 4;

  // STATUS bit positions
  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_RVALID  = 2;
  localparam int unsigned ST_OVERRUN = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 4;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/apb_dram_cmd_fifo.sv
// apb_dram_cmd_fifo: synchronous command FIFO of cmd_t.
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   push_i, push_data_i enqueue request and payload (ignored when full)
//   pop_i               dequeue head (ignored when empty)
//   head_o              current head entry, registered storage
//   empty_o, full_o     occupancy flags derived from the registered count
//   count_o             number of valid entries
module apb_dram_cmd_fifo
  import apb_dram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  cmd_t                   push_data_i,
  input  logic                   pop_i,
  output cmd_t                   head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; power-of-two depth makes pointer wrap free
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared so the cmd_* outputs are quiet after reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q <= '{default: '0};
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/apb_dram_cmd_bridge.sv
// apb_dram_cmd_bridge: APB slave register file that builds DRAM controller requests.
// Ports:
//   pclk, preset                 clock, asynchronous active-low reset
//   psel/penable/pwrite/paddr/pwdata  APB request
//   prdata/pready/pslverr        APB response, combinational, zero outside access phase
//   cmd_valid/cmd_ready          FIFO head handshake toward the controller core
//   cmd_write/cmd_addr/cmd_wdata FIFO head payload
//   rsp_valid/rsp_rdata          single-cycle read-response strobe and data
// Build option: define APB_TIMEOUT_EN to bound a full-FIFO CMD stall to TIMEOUT_CYCLES
// wait cycles, after which the transfer ends with pslverr and no push.
module apb_dram_cmd_bridge
  import apb_dram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
  begin : g_param_check
    $error("apb_dram_cmd_bridge: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  logic              access, cmd_wr, full_wait, timeout_hit, bad_addr;
  logic              xfer, reg_wr, reg_rd, rd_clr, push, pop;
  logic              sel_addr, sel_wdata, sel_cmd, sel_status, sel_rdata;
  logic              fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  cmd_t              push_cmd, head_cmd;
  logic [DATA_W-1:0] status, rd_mux;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              overrun_q, overrun_d;

  // APB decode; reset gating makes an in-flight transfer look idle while preset is low
  assign access     = preset & psel & penable;
  assign sel_addr   = (paddr == ADDR_W'(REG_ADDR));
  assign sel_wdata  = (paddr == ADDR_W'(REG_WDATA));
  assign sel_cmd    = (paddr == ADDR_W'(REG_CMD));
  assign sel_status = (paddr == ADDR_W'(REG_STATUS));
  assign sel_rdata  = (paddr == ADDR_W'(REG_RDATA));
  assign bad_addr   = (paddr > ADDR_W'(REG_RDATA));

  // Stall uses the registered full flag only, so a pop frees the slot one cycle later
  assign cmd_wr    = access & pwrite & sel_cmd;
  assign full_wait = cmd_wr & fifo_full;

  assign pready  = access & (~full_wait | timeout_hit);
  assign pslverr = access & (bad_addr | timeout_hit);

  assign xfer   = access & pready;
  assign reg_wr = xfer & pwrite & ~pslverr;
  assign reg_rd = xfer & ~pwrite;
  assign rd_clr = reg_rd & sel_rdata;
  assign push   = reg_wr & sel_cmd;
  assign pop    = cmd_valid & cmd_ready;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_q, wait_d;

  assign timeout_hit = full_wait & (wait_q == TO_W'(TIMEOUT_CYCLES));

  // Consecutive stall cycles of the current CMD transfer
  always_comb begin
    wait_d = wait_q;
    if (!psel || xfer)  wait_d = '0;
    else if (full_wait) wait_d = wait_q + TO_W'(1);
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) wait_q <= '0;
    else         wait_q <= wait_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    push_cmd       = '0;
    push_cmd.write = pwdata[0];
    push_cmd.addr  = CMD_ADDR_W'(addr_q);
    push_cmd.wdata = CMD_DATA_W'(wdata_q);
  end

  apb_dram_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (pclk),
    .rst_n_i     (preset),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .head_o      (head_cmd),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign cmd_valid = ~fifo_empty;
  assign cmd_write = head_cmd.write;
  assign cmd_addr  = ADDR_W'(head_cmd.addr);
  assign cmd_wdata = DATA_W'(head_cmd.wdata);

  always_comb begin
    status                          = '0;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_FULL]                 = fifo_full;
    status[ST_RVALID]               = rvalid_q;
    status[ST_OVERRUN]              = overrun_q;
    status[ST_CNT_LSB +: ST_CNT_W]  = ST_CNT_W'(fifo_count);
  end

  // Read-data mux; CMD and undecoded offsets read as zero
  always_comb begin
    rd_mux = '0;
    if (access && !pwrite) begin
      if (sel_addr)        rd_mux = DATA_W'(addr_q);
      else if (sel_wdata)  rd_mux = wdata_q;
      else if (sel_status) rd_mux = status;
      else if (sel_rdata)  rd_mux = rdata_q;
    end
  end

  assign prdata = rd_mux;

  // Register next-state; a response landing with an RDATA read keeps RVALID without overrun
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    overrun_d = overrun_q;
    if (reg_wr && sel_addr)                       addr_d    = ADDR_W'(pwdata);
    if (reg_wr && sel_wdata)                      wdata_d   = pwdata;
    if (reg_wr && sel_status && pwdata[ST_OVERRUN]) overrun_d = 1'b0;
    if (rsp_valid) begin
      rdata_d  = rsp_rdata;
      rvalid_d = 1'b1;
      if (rvalid_q && !rd_clr) overrun_d = 1'b1;
    end else if (rd_clr) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_apb_dram_cmd_bridge.sv
// Bench for apb_dram_cmd_bridge: directed scenario tasks plus a randomized run, all
// checked against a transaction-level model (queue + register values) of the bridge.
module tb_apb_dram_cmd_bridge;

  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = 16;
  localparam int WAIT_LIMIT = 100;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0, pwdata = '0;
  logic [15:0] prdata;
  logic        pready, pslverr;
  logic        cmd_valid, cmd_write;
  logic        cmd_ready = 1'b0;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_rdata = '0;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [15:0] rd;
  bit          err;
  int          w;

  apb_dram_cmd_bridge #(
    .FIFO_DEPTH     (DEPTH),
    .ADDR_W         (16),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  always #5 pclk = ~pclk;

  // ---------------- reference model ----------------
  typedef struct { bit w; logic [15:0] a; logic [15:0] d; } ent_t;
  ent_t        q[$];
  logic [15:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  bit          m_rv = 0, m_ovr = 0;
  int          m_wait = 0;

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s      = 16'h0;
    s[0]   = (q.size() == 0);
    s[1]   = (q.size() == DEPTH);
    s[2]   = m_rv;
    s[3]   = m_ovr;
    s[7:4] = 4'(q.size());
    return s;
  endfunction

  function automatic bit cmd_stall();
    return psel && penable && pwrite && (paddr == 16'd2) && (q.size() == DEPTH);
  endfunction

  function automatic bit to_hit();
    return TO_EN && cmd_stall() && (m_wait == TIMEOUT);
  endfunction

  function automatic bit exp_ready();
    return psel && penable && (!cmd_stall() || to_hit());
  endfunction

  function automatic bit exp_err();
    return psel && penable && ((paddr >= 16'd5) || to_hit());
  endfunction

  function automatic logic [15:0] exp_prdata();
    if (!(psel && penable && !pwrite)) return 16'h0;
    case (paddr)
      16'd0:   return m_addr;
      16'd1:   return m_wdata;
      16'd3:   return model_status();
      16'd4:   return m_rdata;
      default: return 16'h0;
    endcase
  endfunction

  bit   mo_xf, mo_er, mo_pop, mo_push, mo_clr, mo_stall;
  ent_t mo_e;

  always @(posedge pclk or negedge preset) begin
    if (!preset) begin
      q.delete();
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_rv = 0; m_ovr = 0; m_wait = 0;
    end else begin
      mo_xf    = psel && penable && exp_ready();
      mo_er    = exp_err();
      mo_stall = cmd_stall();
      mo_pop   = cmd_ready && (q.size() > 0);
      mo_clr   = mo_xf && !pwrite && (paddr == 16'd4);
      mo_push  = mo_xf && pwrite && !mo_er && (paddr == 16'd2);
      mo_e     = '{pwdata[0], m_addr, m_wdata};
      if (!psel || mo_xf) m_wait = 0;
      else if (mo_stall)  m_wait++;
      if (mo_xf && pwrite && !mo_er) begin
        if (paddr == 16'd0) m_addr = pwdata;
        if (paddr == 16'd1) m_wdata = pwdata;
        if (paddr == 16'd3 && pwdata[3]) m_ovr = 0;
      end
      if (rsp_valid) begin
        if (m_rv && !mo_clr) m_ovr = 1;
        m_rdata = rsp_rdata;
        m_rv    = 1;
      end else if (mo_clr) begin
        m_rv = 0;
      end
      if (mo_pop)  void'(q.pop_front());
      if (mo_push) q.push_back(mo_e);
    end
  end

  // Mid-cycle comparison of every output against the model
  always @(negedge pclk) begin
    if (chk_en && preset) begin
      checks++;
      if (pready !== exp_ready()) begin
        failures++;
        $display("FAIL chk_pready t=%0t got=%b exp=%b", $time, pready, exp_ready());
      end
      checks++;
      if (pslverr !== exp_err()) begin
        failures++;
        $display("FAIL chk_pslverr t=%0t got=%b exp=%b", $time, pslverr, exp_err());
      end
      if (!(psel && penable && pwrite)) begin
        checks++;
        if (prdata !== exp_prdata()) begin
          failures++;
          $display("FAIL chk_prdata t=%0t got=%h exp=%h", $time, prdata, exp_prdata());
        end
      end
      checks++;
      if (cmd_valid !== (q.size() > 0)) begin
        failures++;
        $display("FAIL chk_cmd_valid t=%0t got=%b exp=%b", $time, cmd_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (cmd_write !== q[0].w || cmd_addr !== q[0].a || cmd_wdata !== q[0].d) begin
          failures++;
          $display("FAIL chk_cmd_head t=%0t got=%b/%h/%h exp=%b/%h/%h", $time,
                   cmd_write, cmd_addr, cmd_wdata, q[0].w, q[0].a, q[0].d);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge pclk); #1;
  endtask

  // One APB transfer starting at posedge+1; returns at posedge+1 after completion
  task automatic apb(input bit wr, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] r, output bit e, output int waits);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1 penable = 1'b1;
    waits = 0;
    @(negedge pclk);
    while (pready !== 1'b1 && waits < WAIT_LIMIT) begin
      waits++;
      @(negedge pclk);
    end
    checks++;
    if (pready !== 1'b1) begin
      failures++;
      $display("FAIL apb_no_ready addr=%h got=%b exp=1 after %0d cycles", a, pready, waits);
    end
    r = prdata;
    e = pslverr;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulse_rsp(input logic [15:0] d);
    rsp_valid = 1'b1; rsp_rdata = d;
    @(posedge pclk); #1 rsp_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    preset = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 16'd3;
    #12;
    checks++; if (pready !== 1'b0)  begin failures++; $display("FAIL reset_pready got=%b exp=0", pready); end
    checks++; if (pslverr !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
    checks++; if (prdata !== 16'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #3 preset = 1'b1;
    sync();
    chk_en = 1'b1;
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL reset_status got=%h exp=0001", rd); end
    apb(0, 16'd0, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", rd); end
    apb(0, 16'd4, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rd); end
  endtask

  task automatic test_basic();
    sync();
    cmd_ready = 1'b1;
    apb(1, 16'd0, 16'h1234, rd, err, w);
    checks++; if (w !== 0) begin failures++; $display("FAIL basic_addr_waits got=%0d exp=0", w); end
    apb(1, 16'd1, 16'hBEEF, rd, err, w);
    checks++; if (w !== 0) begin failures++; $display("FAIL basic_wdata_waits got=%0d exp=0", w); end
    apb(1, 16'd2, 16'h0001, rd, err, w);
    checks++; if (w !== 0) begin failures++; $display("FAIL basic_cmd_waits got=%0d exp=0", w); end
    @(negedge pclk);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_write !== 1'b1 || cmd_addr !== 16'h1234 || cmd_wdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL basic_cmd_out got=%b/%b/%h/%h exp=1/1/1234/beef", cmd_valid, cmd_write, cmd_addr, cmd_wdata);
    end
  endtask

  task automatic test_full();
    sync();
    cmd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      apb(1, 16'd0, 16'(16'h0100 + i), rd, err, w);
      apb(1, 16'd2, 16'(i & 1), rd, err, w);
    end
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h0042) begin failures++; $display("FAIL full_status got=%h exp=0042", rd); end
    // fifth write stalls until a pop frees a slot
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd2; pwdata = 16'h0001;
    @(posedge pclk); #1 penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      checks++; if (pready !== 1'b0) begin failures++; $display("FAIL full_stall%0d got=%b exp=0", i, pready); end
    end
    @(posedge pclk); #1 cmd_ready = 1'b1;
    @(negedge pclk);
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL full_pop_cycle got=%b exp=0", pready); end
    @(posedge pclk); #1 cmd_ready = 1'b0;
    @(negedge pclk);
    checks++; if (pready !== 1'b1) begin failures++; $display("FAIL full_release got=%b exp=1", pready); end
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h0042) begin failures++; $display("FAIL full_status_after got=%h exp=0042", rd); end
  endtask

  task automatic test_timeout();
    sync();
    apb(1, 16'd2, 16'h0001, rd, err, w);
    checks++; if (w !== TIMEOUT) begin failures++; $display("FAIL timeout_waits got=%0d exp=%0d", w, TIMEOUT); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", err); end
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h0042) begin failures++; $display("FAIL timeout_status got=%h exp=0042", rd); end
  endtask

  task automatic test_stall_reset();
    sync();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd2; pwdata = 16'h0000;
    @(posedge pclk); #1 penable = 1'b1;
    repeat (TO_EN ? 5 : 3 * TIMEOUT) @(negedge pclk);
    checks++; if (pready !== 1'b0) begin failures++; $display("FAIL stall_hold got=%b exp=0", pready); end
    @(posedge pclk); #3;
    chk_en = 1'b0;
    preset = 1'b0;
    #1;
    checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 16'h0 || cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_reset_apb got=%b/%b/%h/%b exp=0/0/0000/0", pready, pslverr, prdata, cmd_valid);
    end
    checks++;
    if (cmd_write !== 1'b0 || cmd_addr !== 16'h0 || cmd_wdata !== 16'h0) begin
      failures++;
      $display("FAIL stall_reset_cmd got=%b/%h/%h exp=0/0000/0000", cmd_write, cmd_addr, cmd_wdata);
    end
    #1 psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #3 preset = 1'b1;
    sync();
    chk_en = 1'b1;
    cmd_ready = 1'b1;
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL stall_reset_status got=%h exp=0001", rd); end
  endtask

  task automatic test_rsp();
    sync();
    pulse_rsp(16'hA5A5);
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd[2] !== 1'b1) begin failures++; $display("FAIL rsp_rvalid_set got=%b exp=1", rd[2]); end
    apb(0, 16'd4, 16'h0, rd, err, w);
    checks++; if (rd !== 16'hA5A5) begin failures++; $display("FAIL rsp_rdata got=%h exp=a5a5", rd); end
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd[2] !== 1'b0) begin failures++; $display("FAIL rsp_rvalid_clr got=%b exp=0", rd[2]); end
  endtask

  task automatic test_overrun();
    sync();
    pulse_rsp(16'h0001);
    pulse_rsp(16'h0002);
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd[3] !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", rd[3]); end
    apb(0, 16'd4, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h0002) begin failures++; $display("FAIL ovr_rdata got=%h exp=0002", rd); end
    apb(1, 16'd3, 16'h0008, rd, err, w);
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd[3] !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", rd[3]); end
  endtask

  task automatic test_rsp_collide();
    sync();
    pulse_rsp(16'h1111);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'd4;
    @(posedge pclk); #1 penable = 1'b1; rsp_valid = 1'b1; rsp_rdata = 16'h7777;
    @(negedge pclk);
    checks++; if (prdata !== 16'h1111) begin failures++; $display("FAIL collide_old got=%h exp=1111", prdata); end
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; rsp_valid = 1'b0;
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd[3:2] !== 2'b01) begin failures++; $display("FAIL collide_flags got=%b exp=01", rd[3:2]); end
    apb(0, 16'd4, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h7777) begin failures++; $display("FAIL collide_new got=%h exp=7777", rd); end
  endtask

  task automatic test_bad_addr();
    sync();
    apb(1, 16'd0, 16'h5A5A, rd, err, w);
    apb(0, 16'd7, 16'h0, rd, err, w);
    checks++; if (err !== 1'b1 || rd !== 16'h0 || w !== 0) begin failures++; $display("FAIL bad_rd got=%b/%h/%0d exp=1/0000/0", err, rd, w); end
    apb(1, 16'd7, 16'hFFFF, rd, err, w);
    checks++; if (err !== 1'b1 || w !== 0) begin failures++; $display("FAIL bad_wr got=%b/%0d exp=1/0", err, w); end
    apb(1, 16'd5, 16'h0000, rd, err, w);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_wr5 got=%b exp=1", err); end
    apb(0, 16'd0, 16'h0, rd, err, w);
    checks++; if (rd !== 16'h5A5A || err !== 1'b0) begin failures++; $display("FAIL bad_addr_keep got=%h/%b exp=5a5a/0", rd, err); end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    sync();
    fork
      begin
        while (!done) begin
          @(posedge pclk); #1;
          if (!done) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            rsp_valid = ($urandom_range(0, 4) == 0);
            rsp_rdata = 16'($urandom);
          end
        end
      end
      begin
        for (int i = 0; i < 150; i++)
          apb(bit'($urandom_range(0, 1)), 16'($urandom_range(0, 6)), 16'($urandom), rd, err, w);
        done = 1'b1;
      end
    join
    rsp_valid = 1'b0;
    cmd_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge pclk);
    #1;
    apb(0, 16'd3, 16'h0, rd, err, w);
    checks++; if (rd !== model_status() || rd[0] !== 1'b1) begin failures++; $display("FAIL rand_status got=%h exp=%h", rd, model_status()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_stall_reset();
    test_rsp();
    test_overrun();
    test_rsp_collide();
    test_bad_addr();
    test_random();
    repeat (2) @(posedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
